// File: rtl/instr_encoder.sv
// Program loader: packs instruction fields into 49-bit decoder words and writes them
// sequentially into instruction RAM, rejecting malformed bundles with a sticky error.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter logic [4:0]  OP_MAX = 5'h0F
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [4:0]        i_op,
    input  logic [1:0]        i_md,
    input  logic [31:0]       i_src,
    input  logic [31:0]       i_dst,
    input  logic [31:0]       i_literal,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [48:0]       o_imem_wdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [4:0]      OP_LD   = 5'h01;
    localparam logic [4:0]      OP_ST   = 5'h02;

    typedef enum logic [1:0] {StIdle, StPack, StWrite, StFull} state_e;

    state_e              r_state;
    logic [4:0]          r_op;
    logic [1:0]          r_md;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [31:0]         r_lit;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [48:0]         r_wdata;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_full;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic [31:0]         w_slot_a;
    logic [31:0]         w_slot_b;
    logic [31:0]         w_wide;
    logic                w_ovf;
    logic [1:0]          w_code;
    logic [48:0]         w_word;
    logic [ADDR_W:0]     w_count_inc;

    // Inverse of the decoder's swaps: ST and direct LD move fields between slots.
    always_comb begin
        w_slot_a = r_src;
        w_slot_b = r_dst;
        w_wide   = r_lit;
        if (r_op == OP_ST) begin
            w_slot_a = r_src;
            w_slot_b = r_lit;
            w_wide   = r_dst;
        end else if (r_op == OP_LD && r_md == 2'b01) begin
            w_slot_a = r_lit;
            w_slot_b = r_dst;
            w_wide   = r_src;
        end
    end

    assign w_ovf  = (|w_slot_a[31:5]) | (|w_slot_b[31:5]);
    assign w_word = {r_op, r_md, w_slot_a[4:0], w_slot_b[4:0], w_wide};

    always_comb begin
        w_code = 2'b00;
        if (r_op > OP_MAX) begin
            w_code = 2'b11;
        end else if (r_md == 2'b11) begin
            w_code = 2'b01;
        end else if (w_ovf) begin
            w_code = 2'b10;
        end
    end

    assign w_count_inc = r_count + (ADDR_W + 1)'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_op       <= '0;
            r_md       <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_lit      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else if (i_clear) begin
            // Abort any word in flight; err_code keeps the last recorded cause.
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_op    <= i_op;
                        r_md    <= i_md;
                        r_src   <= i_src;
                        r_dst   <= i_dst;
                        r_lit   <= i_literal;
                        r_state <= StPack;
                    end
                end
                StPack: begin
                    if (w_code != 2'b00) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_code;
                        r_state    <= StIdle;
                    end else begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= w_word;
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    r_ptr   <= r_ptr + ADDR_W'(1);
                    r_count <= w_count_inc;
                    if (w_count_inc == DEPTH_W) begin
                        r_full  <= 1'b1;
                        r_state <= StFull;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StFull: r_state <= StFull;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Strobe is gated so a clear or reset in the write cycle drops the word immediately.
    assign o_imem_we    = r_we & ~i_clear & ~i_rst;
    assign o_in_ready   = (r_state == StIdle) & ~i_clear & ~i_rst;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_count      = r_count;
    assign o_full       = r_full;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4): vector table for packing and reject
// causes, plus hand sequences for fill-to-full, clear in PACK and clear in WRITE.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op;
    logic [1:0]        md;
    logic [31:0]       src;
    logic [31:0]       dst;
    logic [31:0]       lit;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [48:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    instr_encoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .OP_MAX (5'h0F)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clear),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_op         (op),
        .i_md         (md),
        .i_src        (src),
        .i_dst        (dst),
        .i_literal    (lit),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_count      (count),
        .o_full       (full),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  md;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] lit;
        logic        exp_we;
        logic [48:0] exp_word;
        logic [1:0]  exp_code;
    } vec_t;

    int          n_vec;
    int          n_bad;
    int          exp_count;
    logic [7:0]  exp_ptr;
    logic        exp_err;
    logic [1:0]  exp_code;
    vec_t        vecs[10];

    function automatic vec_t mk(input logic [4:0] o, input logic [1:0] m, input logic [31:0] s,
                                input logic [31:0] d, input logic [31:0] l, input logic we,
                                input logic [48:0] w, input logic [1:0] c);
        vec_t v;
        v.op = o; v.md = m; v.src = s; v.dst = d; v.lit = l;
        v.exp_we = we; v.exp_word = w; v.exp_code = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents a bundle and returns one cycle after the accepting edge (PACK cycle).
    task automatic send(input vec_t v, output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        op = v.op; md = v.md; src = v.src; dst = v.dst; lit = v.lit;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        send(v, ok);
        if (!ok) return;
        chk({tag, "_we_pack"}, {63'd0, imem_we}, 64'd0);
        tick();
        chk({tag, "_we_write"}, {63'd0, imem_we}, {63'd0, v.exp_we});
        if (v.exp_we) begin
            chk({tag, "_addr"}, {56'd0, imem_addr}, {56'd0, exp_ptr});
            chk({tag, "_wdata"}, {15'd0, imem_wdata}, {15'd0, v.exp_word});
            exp_ptr++;
            exp_count++;
        end else begin
            exp_err  = 1'b1;
            exp_code = v.exp_code;
        end
        tick();
        chk({tag, "_we_after"}, {63'd0, imem_we}, 64'd0);
        chk({tag, "_count"}, {55'd0, count}, 64'(exp_count));
        chk({tag, "_full"}, {63'd0, full}, {63'd0, exp_count == DEPTH});
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        if (exp_err) chk({tag, "_err_code"}, {62'd0, err_code}, {62'd0, exp_code});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        chk("clear_ready", {63'd0, in_ready}, 64'd0);
        tick();
        clear = 1'b0;
        #1;
        exp_count = 0;
        exp_ptr   = '0;
        exp_err   = 1'b0;
        chk("clear_count", {55'd0, count}, 64'd0);
        chk("clear_full", {63'd0, full}, 64'd0);
        chk("clear_err", {63'd0, err}, 64'd0);
        chk("clear_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        bit   ok;
        vec_t v;
        n_vec = 0; n_bad = 0;
        exp_count = 0; exp_ptr = '0; exp_err = 1'b0; exp_code = 2'b00;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        op = '0; md = '0; src = '0; dst = '0; lit = '0;

        vecs[0] = mk(5'h03, 2'b00, 32'd4, 32'd7, 32'h1234, 1'b1,
                     {5'h03, 2'b00, 5'd4, 5'd7, 32'h1234}, 2'b00);
        vecs[1] = mk(5'h02, 2'b00, 32'd3, 32'h100, 32'd9, 1'b1,
                     {5'h02, 2'b00, 5'd3, 5'd9, 32'h100}, 2'b00);
        vecs[2] = mk(5'h03, 2'b11, 32'd1, 32'd1, 32'd0, 1'b0, '0, 2'b01);
        vecs[3] = mk(5'h10, 2'b00, 32'd1, 32'd1, 32'd0, 1'b0, '0, 2'b11);
        vecs[4] = mk(5'h1F, 2'b11, 32'h99, 32'd0, 32'd0, 1'b0, '0, 2'b11);
        vecs[5] = mk(5'h01, 2'b11, 32'd0, 32'd0, 32'h40, 1'b0, '0, 2'b01);
        vecs[6] = mk(5'h03, 2'b00, 32'd1, 32'd32, 32'd0, 1'b0, '0, 2'b10);
        vecs[7] = mk(5'h02, 2'b00, 32'd1, 32'd0, 32'h20, 1'b0, '0, 2'b10);
        vecs[8] = mk(5'h01, 2'b01, 32'h40, 32'd6, 32'd2, 1'b1,
                     {5'h01, 2'b01, 5'd2, 5'd6, 32'h40}, 2'b00);
        vecs[9] = mk(5'h01, 2'b00, 32'd5, 32'd6, 32'hDEAD, 1'b1,
                     {5'h01, 2'b00, 5'd5, 5'd6, 32'hDEAD}, 2'b00);

        // Reset: two cycles, outputs cleared, ready only once reset drops.
        tick();
        tick();
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_we", {63'd0, imem_we}, 64'd0);
        chk("rst_addr", {56'd0, imem_addr}, 64'd0);
        chk("rst_wdata", {15'd0, imem_wdata}, 64'd0);
        chk("rst_count", {55'd0, count}, 64'd0);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_err_code", {62'd0, err_code}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Full: a held bundle must be ignored.
        v = vecs[0];
        op = v.op; md = v.md; src = v.src; dst = v.dst; lit = v.lit;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("full_ready", {63'd0, in_ready}, 64'd0);
            chk("full_we", {63'd0, imem_we}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_count_hold", {55'd0, count}, 64'd4);
        do_clear();

        // Five back-to-back bundles into a 4-deep memory.
        for (int i = 0; i < 4; i++) begin
            v = mk(5'h03, 2'b00, 32'(i), 32'(i + 1), 32'(i * 16 + 5), 1'b1,
                   {5'h03, 2'b00, 5'(i), 5'(i + 1), 32'(i * 16 + 5)}, 2'b00);
            run_vec(v, $sformatf("fill%0d", i));
        end
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("fifth_we", {63'd0, imem_we}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("fifth_full", {63'd0, full}, 64'd1);
        chk("fifth_count", {55'd0, count}, 64'd4);
        do_clear();

        // Clear during PACK discards the bundle.
        send(vecs[0], ok);
        if (ok) begin
            clear = 1'b1;
            #1;
            chk("clrpack_we0", {63'd0, imem_we}, 64'd0);
            tick();
            clear = 1'b0;
            chk("clrpack_we1", {63'd0, imem_we}, 64'd0);
            tick();
            chk("clrpack_we2", {63'd0, imem_we}, 64'd0);
            chk("clrpack_count", {55'd0, count}, 64'd0);
        end
        run_vec(vecs[1], "after_clrpack");

        // Clear during WRITE suppresses the strobe that cycle.
        send(vecs[8], ok);
        if (ok) begin
            tick();
            clear = 1'b1;
            #1;
            chk("clrwrite_we", {63'd0, imem_we}, 64'd0);
            tick();
            clear = 1'b0;
            #1;
            chk("clrwrite_count", {55'd0, count}, 64'd0);
            chk("clrwrite_ready", {63'd0, in_ready}, 64'd1);
        end
        exp_count = 0;
        exp_ptr   = '0;
        run_vec(vecs[9], "after_clrwrite");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
